// File: rtl/dcf_frame_decoder_if.sv
// Signal bundle between the DCF77 frame decoder and its tick source / time consumer.
// master drives tick and dcf_in; slave is the decoder.
interface dcf_frame_decoder_if;
  logic       tick;
  logic       dcf_in;
  logic [7:0] minute;
  logic [7:0] hour;
  logic       frame_valid;
  logic       locked;
  logic       err;
  logic [5:0] bit_idx;

  modport master (
    output tick, dcf_in,
    input  minute, hour, frame_valid, locked, err, bit_idx
  );

  modport slave (
    input  tick, dcf_in,
    output minute, hour, frame_valid, locked, err, bit_idx
  );
endinterface

// File: rtl/dcf_frame_decoder.sv
// DCF77 pulse classifier and minute-frame assembler; strobes decoded minute/hour on a good frame.
// Define DCF_PARITY_CHECK_EN to require even parity on the minute, hour and date fields.
module dcf_frame_decoder #(
  parameter int unsigned ZERO_MIN   = 5,
  parameter int unsigned ONE_MIN    = 15,
  parameter int unsigned ONE_MAX    = 25,
  parameter int unsigned MARK_MIN   = 150,
  parameter int unsigned LOSS_TICKS = 250
) (
  input logic                CLOCK_50,
  input logic                reset,
  dcf_frame_decoder_if.slave dcf
);

  typedef enum logic [1:0] {StSeek = 2'b00, StRecv = 2'b01} state_e;

  localparam logic [7:0] ZeroMin   = 8'(ZERO_MIN);
  localparam logic [7:0] OneMin    = 8'(ONE_MIN);
  localparam logic [7:0] OneMax    = 8'(ONE_MAX);
  localparam logic [7:0] MarkMin   = 8'(MARK_MIN);
  localparam logic [7:0] LossTicks = 8'(LOSS_TICKS);
  localparam logic [5:0] LastIdx   = 6'd59;
  localparam logic [5:0] LowBit    = 6'd20;

  // Bits below 20 carry no checked field, so only the checked span is kept.
`ifdef DCF_PARITY_CHECK_EN
  localparam logic [5:0] TopBit = 6'd58;
`else
  localparam logic [5:0] TopBit = 6'd34;
`endif

  logic                sync1_q, sync2_q, s_q;
  logic [7:0]          hi_cnt_q, hi_cnt_d;
  logic [7:0]          gap_cnt_q, gap_cnt_d, gap_inc;
  logic [7:0]          gap_lat_q, gap_lat_d;
  state_e              state_q, state_d;
  logic [5:0]          bit_idx_q, bit_idx_d;
  logic [TopBit:LowBit] frame_q, frame_d;
  logic [7:0]          minute_q, minute_d, hour_q, hour_d;
  logic                fv_q, fv_d, err_q, err_d;

  logic       rise, fall, pulse_valid, pulse_bad, bit_val, marker, loss;
  logic [3:0] min_u, hr_u;
  logic [2:0] min_t;
  logic [1:0] hr_t;
  logic       bcd_ok, par_ok, frame_ok;
  logic [7:0] min_bin, hr_bin;

  assign rise = dcf.tick & sync2_q & ~s_q;
  assign fall = dcf.tick & ~sync2_q & s_q;

  assign pulse_valid = fall && (hi_cnt_q >= ZeroMin) && (hi_cnt_q <= OneMax);
  assign pulse_bad   = fall && (hi_cnt_q > OneMax);
  assign bit_val     = (hi_cnt_q >= OneMin);
  assign marker      = (gap_lat_q >= MarkMin);

  assign gap_inc = (gap_cnt_q == 8'hFF) ? gap_cnt_q : gap_cnt_q + 8'd1;
  // Fires only on the tick that first reaches the threshold; saturation keeps it quiet after.
  assign loss    = dcf.tick && !pulse_valid && (gap_inc == LossTicks) && (gap_cnt_q != LossTicks);

  assign min_u = frame_q[24:21];
  assign min_t = frame_q[27:25];
  assign hr_u  = frame_q[32:29];
  assign hr_t  = frame_q[34:33];

  assign bcd_ok = frame_q[20] && (min_u <= 4'd9) && (min_t <= 3'd5) && (hr_u <= 4'd9) &&
                  ((hr_t < 2'd2) || ((hr_t == 2'd2) && (hr_u <= 4'd3)));

`ifdef DCF_PARITY_CHECK_EN
  assign par_ok = ~(^frame_q[28:21]) & ~(^frame_q[35:29]) & ~(^frame_q[58:36]);
`else
  assign par_ok = 1'b1;
`endif

  assign frame_ok = bcd_ok & par_ok;
  assign min_bin  = {5'd0, min_t} * 8'd10 + {4'd0, min_u};
  assign hr_bin   = {6'd0, hr_t} * 8'd10 + {4'd0, hr_u};

  always_comb begin
    hi_cnt_d  = hi_cnt_q;
    gap_cnt_d = gap_cnt_q;
    gap_lat_d = gap_lat_q;
    if (dcf.tick) begin
      if (sync2_q) begin
        hi_cnt_d = rise ? 8'd1 : ((hi_cnt_q == 8'hFF) ? hi_cnt_q : hi_cnt_q + 8'd1);
      end
      gap_cnt_d = pulse_valid ? 8'd0 : gap_inc;
      if (rise) begin
        gap_lat_d = gap_cnt_q;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    frame_d   = frame_q;
    minute_d  = minute_q;
    hour_d    = hour_q;
    fv_d      = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      StSeek: begin
        if (pulse_valid && marker) begin
          bit_idx_d = 6'd1;
          state_d   = StRecv;
        end
      end
      StRecv: begin
        if (pulse_bad || loss) begin
          err_d     = 1'b1;
          state_d   = StSeek;
          bit_idx_d = 6'd0;
        end else if (pulse_valid) begin
          if (marker && (bit_idx_q == LastIdx)) begin
            if (frame_ok) begin
              fv_d     = 1'b1;
              minute_d = min_bin;
              hour_d   = hr_bin;
            end else begin
              err_d = 1'b1;
            end
            bit_idx_d = 6'd1;
          end else if (marker || (bit_idx_q == LastIdx)) begin
            err_d     = 1'b1;
            state_d   = StSeek;
            bit_idx_d = 6'd0;
          end else begin
            if ((bit_idx_q >= LowBit) && (bit_idx_q <= TopBit)) begin
              frame_d[bit_idx_q] = bit_val;
            end
            bit_idx_d = bit_idx_q + 6'd1;
          end
        end
      end
      default: begin
        state_d   = StSeek;
        bit_idx_d = 6'd0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      s_q       <= 1'b0;
      hi_cnt_q  <= 8'd0;
      gap_cnt_q <= 8'd0;
      gap_lat_q <= 8'd0;
      state_q   <= StSeek;
      bit_idx_q <= 6'd0;
      frame_q   <= '0;
      minute_q  <= 8'd0;
      hour_q    <= 8'd0;
      fv_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      sync1_q   <= dcf.dcf_in;
      sync2_q   <= sync1_q;
      if (dcf.tick) begin
        s_q <= sync2_q;
      end
      hi_cnt_q  <= hi_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      gap_lat_q <= gap_lat_d;
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      frame_q   <= frame_d;
      minute_q  <= minute_d;
      hour_q    <= hour_d;
      fv_q      <= fv_d;
      err_q     <= err_d;
    end
  end

  assign dcf.minute      = minute_q;
  assign dcf.hour        = hour_q;
  assign dcf.frame_valid = fv_q;
  assign dcf.err         = err_q;
  assign dcf.locked      = (state_q == StRecv);
  assign dcf.bit_idx     = bit_idx_q;

endmodule

// File: doc/dcf_frame_decoder.md
# dcf_frame_decoder

Upstream DCF77 front end for the digital clock: samples the raw receiver output on the 100 Hz tick, classifies each carrier pulse as 0, 1 or glitch, finds the minute marker, and assembles the 59-bit frame. On a frame that passes all checks it presents decoded minute and hour in binary with a one-cycle `frame_valid` strobe. The clock state machine uses this strobe to load its time registers, replacing its own sync and listen states.

## Interface
Parameters:
- `ZERO_MIN`, 5: minimum high ticks for a valid pulse; shorter pulses are glitches.
- `ONE_MIN`, 15: high ticks at or above this decode as 1; below it, as 0.
- `ONE_MAX`, 25: high ticks above this are a pulse error.
- `MARK_MIN`, 150: minimum gap ticks that mark a minute boundary.
- `LOSS_TICKS`, 250: gap ticks at which the signal counts as lost.

Ports:
- `CLOCK_50`  in  1  system clock. One clock; reset is synchronous and active-high.
- `reset`  in  1  synchronous, active-high.
- `tick`  in  1  100 Hz clock enable, one `CLOCK_50` cycle wide, from the frequency divider.
- `dcf_in`  in  1  raw receiver output, asynchronous; high = pulse.
- `minute`  out  8  decoded minute in binary, 0–59.
- `hour`  out  8  decoded hour in binary, 0–23.
- `frame_valid`  out  1  one-cycle strobe when `minute`/`hour` are updated.
- `locked`  out  1  high while in RECV.
- `err`  out  1  one-cycle strobe on any frame rejection.
- `bit_idx`  out  6  index of the next bit to store, 0–59 (debug/LED).

## Operation
- Input path: `dcf_in` passes through a 2-flop synchronizer on `CLOCK_50`. The result is sampled into `s` only on `tick`. Edges are detected between consecutive `tick` samples.
- `hi_cnt` (8 bit, saturating) counts `tick`s while `s` is 1. It clears on the rising edge.
- `gap_cnt` (8 bit, saturating) counts `tick`s since the last *valid* falling edge. Glitch pulses do not clear it.
- On each falling edge, the pulse is classified by `hi_cnt`:
  - below `ZERO_MIN`: glitch. It is discarded, with no state change and no error.
  - `ZERO_MIN` to `ONE_MIN-1`: bit 0.
  - `ONE_MIN` to `ONE_MAX`: bit 1.
  - above `ONE_MAX`: pulse error.
- Boundary rule: the gap used for a valid pulse is the value `gap_cnt` held at that pulse's rising edge, latched at the rising edge. `gap >= MARK_MIN` means this pulse is bit 0 of a new minute.
- States (2 bit):
  - SEEK, entered at reset:
    - On a valid pulse whose gap is at least `MARK_MIN`: store bit 0, set `bit_idx`=1, go to RECV.
    - All other valid pulses are ignored.
  - RECV:
    - Each valid pulse with a short gap stores its bit at `bit_idx` in a 59-bit shift register, then `bit_idx`+1.
    - On a marker pulse with `bit_idx`==59, run the checks:
      - bit 20 = 1;
      - minute BCD (bits 21–27) has units ≤ 9 and value ≤ 59;
      - hour BCD (bits 29–34) has units ≤ 9 and value ≤ 23;
      - plus parity (see Configuration).
    - Checks pass: update `minute`/`hour` (BCD converted to binary as tens×10 + units), pulse `frame_valid`, restart capture at `bit_idx`=1 with the marker as bit 0, stay in RECV.
    - Checks fail: pulse `err`, restart capture as above, stay in RECV.
  - Any of the following pulses `err` and sends the state machine to SEEK with `bit_idx`=0:
    - a marker pulse with `bit_idx`≠59;
    - a short-gap pulse arriving when `bit_idx`==59;
    - a pulse error;
    - `gap_cnt` reaching `LOSS_TICKS`.
  - The unused state encoding recovers to SEEK on the next cycle, with no strobe.
- `minute`/`hour` hold their last good values through errors and SEEK. They clear only on reset.
- Minutes are bit 0 aligned. `frame_valid` therefore fires at the end of the second-0 pulse, about 100 ms after the minute boundary. The consumer loads sec=0 and cent=10 on it.

## Timing
- Reset values:
  - `minute`=0, `hour`=0, `frame_valid`=0, `err`=0, `locked`=0, `bit_idx`=0;
  - state SEEK;
  - all counters 0.
- Reset mid-frame abandons capture immediately, with no strobe.
- Latency: `frame_valid`/`err` are asserted the `CLOCK_50` cycle after the `tick` on which the falling edge was sampled. `minute`/`hour` change in the same cycle as `frame_valid`.
- Strobes are exactly one `CLOCK_50` cycle wide. `err` and `frame_valid` are never asserted together.
- Loss of signal: `err` fires the cycle after the `tick` on which `gap_cnt` reaches `LOSS_TICKS`. `gap_cnt` then stays saturated with no further `err` until a valid pulse.
- `tick` low: nothing advances except the synchronizer.

## Configuration
- `DCF_PARITY_CHECK_EN`, when defined: even parity is required as part of the frame checks:
  - bit 28 over bits 21–28;
  - bit 35 over bits 29–35;
  - bit 58 over bits 36–58.
  - Any failure rejects the frame.
- When undefined: parity bits are captured but ignored. Only bit 20, BCD and range checks apply.

## Test plan
- Reset, then two full frames encoding 13:47 with correct parity (gap 80, 0=10 ticks, 1=20 ticks, marker gap 180) -> `locked`=1 after the first marker; after the second marker, `frame_valid` one cycle, `minute`=47, `hour`=13.
- Same frame with a 2-tick glitch inserted mid-gap and a 3-tick glitch mid-pulse-train -> identical decode, no `err`.
- Frame with bit 28 inverted -> with the macro: `err`, `minute`/`hour` unchanged; without the macro: `frame_valid`, `minute`=47.
- Marker arriving after 58 bits -> `err`, `locked`=0, `bit_idx`=0; the next complete frame decodes correctly.
- Input held low for 260 ticks in RECV -> one `err` at gap 250, state SEEK, outputs retain 13:47.
- Minute field BCD 0x5A, or hour field 0x24, with parity correct -> `err`, no `frame_valid`.
